// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed byte stream (ON, length, words, STOP)
// and writes 32-bit little-endian words into instruction memory.
//
// state  | meaning
// S_IDLE | waiting for ON_BYTE; core released
// S_LEN  | collecting the 16-bit little-endian word count
// S_DATA | assembling 4-byte words and issuing memory writes
// S_STOP | expecting STP_BYTE to confirm the load
module uart_boot_loader #(
    parameter logic [7:0] ON_BYTE     = 8'hAA,
    parameter logic [7:0] STP_BYTE    = 8'h55,
    parameter int         ADDR_W      = 14,
    parameter int         BASE_ADDR   = 0,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]     TMR_LOAD = TW'(TIMEOUT_CYC);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_STOP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [15:0]       words_left_q, words_left_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              timeout;
    logic [15:0]       len_word;

    assign len_word = {rx_data, shift_q[7:0]};

    // Idle timer is a down-counter reloaded on every accepted byte.
    assign timeout = (state_q != S_IDLE) && !rx_valid && (tmr_q == '0);

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        words_left_d = words_left_q;
        index_d      = index_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = 1'b0;
        err_d        = err_q;
        tmr_d        = (rx_valid || state_q == S_IDLE) ? TMR_LOAD : tmr_q - 1'b1;

        if (timeout) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == ON_BYTE) begin
                        state_d    = S_LEN;
                        err_d      = 1'b0;
                        byte_cnt_d = 2'd0;
                        index_d    = '0;
                    end
                end
                S_LEN: begin
                    if (byte_cnt_q == 2'd0) begin
                        shift_d[7:0] = rx_data;
                        byte_cnt_d   = 2'd1;
                    end else begin
                        byte_cnt_d   = 2'd0;
                        words_left_d = len_word;
                        state_d      = (len_word == 16'd0) ? S_STOP : S_DATA;
                    end
                end
                S_DATA: begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    shift_d    = {rx_data, shift_q[23:8]};
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = BASE + index_q;
                        mem_wdata_d  = {rx_data, shift_q};
                        index_d      = index_q + 1'b1;
                        words_left_d = words_left_q - 1'b1;
                        if (words_left_q == 16'd1) begin
                            state_d = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (rx_data == STP_BYTE) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= 2'd0;
            shift_q      <= '0;
            words_left_q <= '0;
            index_q      <= '0;
            tmr_q        <= TMR_LOAD;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            words_left_q <= words_left_d;
            index_q      <= index_d;
            tmr_q        <= tmr_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    // Core is held in reset by our own reset as well as by any active load.
    assign cpu_rst   = rst | busy_q;

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 SHALL have parameter ON_BYTE, default 8'hAA: the start-of-load command byte.
REQ-002 SHALL have parameter STP_BYTE, default 8'h55: the end-of-load confirmation byte.
REQ-003 SHALL have parameter ADDR_W, default 14: the width of the word address.
REQ-004 SHALL have parameter BASE_ADDR, default 0: the word address of the first loaded word.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1000000: the number of idle cycles allowed between bytes during a load.
REQ-006 SHALL have port Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port rx_data, input, 8 bits: a received UART byte.
REQ-009 SHALL have port rx_valid, input, 1 bit: a 1-cycle strobe; rx_data is valid while it is high.
REQ-010 SHALL have port mem_we, output, 1 bit: instruction-memory word write strobe.
REQ-011 SHALL have port mem_addr, output, ADDR_W bits: the word address for the write.
REQ-012 SHALL have port mem_wdata, output, 32 bits: the write data.
REQ-013 SHALL have port cpu_rst, output, 1 bit: core reset request, held high while a load is in progress.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit: a 1-cycle pulse on a successful load.
REQ-016 SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-017 SHALL implement FSM states IDLE, LEN, DATA, STOP; bytes are consumed only in cycles where rx_valid=1.
REQ-018 IDLE: on rx_data==ON_BYTE SHALL go to LEN, clear err, clear the byte counter and word index; any other byte SHALL be ignored.
REQ-019 LEN: SHALL take 2 bytes as a 16-bit little-endian word count N.
- N==0: go to STOP.
- Otherwise: go to DATA.
REQ-020 DATA: SHALL assemble 4 bytes little-endian, first byte to bits [7:0], into a 32-bit word.
REQ-021 After the 4th byte of a word arrives, mem_we SHALL be 1 for exactly the next cycle, with mem_addr = BASE_ADDR + index (mod 2^ADDR_W) and mem_wdata = the assembled word.
REQ-022 SHALL increment index after each write; after word N is written SHALL go to STOP.
REQ-023 Index and address arithmetic SHALL wrap modulo 2^ADDR_W when N > 2^ADDR_W, with no error raised.
REQ-024 STOP: rx_data==STP_BYTE SHALL give a done pulse in the next cycle and a return to IDLE; any other byte SHALL set err and return to IDLE.
REQ-025 A timeout counter SHALL clear on every rx_valid and on entry to LEN.
REQ-026 The timeout counter SHALL count cycles in LEN, DATA and STOP.
REQ-027 When the timeout counter reaches TIMEOUT_CYC SHALL set err and return to IDLE, discarding any partial word; no write SHALL occur.
REQ-028 cpu_rst SHALL be 1 in LEN, DATA and STOP, and 0 in IDLE, including after done or err.
REQ-029 An ON_BYTE received outside IDLE SHALL be treated as ordinary data; no restart occurs.
REQ-030 rx_valid in the same cycle as mem_we SHALL be accepted without loss; the write path is registered.
REQ-031 mem_we SHALL be 0 whenever the FSM is not completing a word.

Reset
REQ-032 While rst=1, the state SHALL go to IDLE in the following cycle.
REQ-033 While rst=1, mem_we, done, err and busy SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-034 While rst=1, cpu_rst SHALL be 1; it SHALL drop to 0 in the first cycle after rst deasserts.
REQ-035 rst asserted mid-load SHALL abort the load with no further writes; err SHALL stay 0.

Verification
REQ-036 Byte stream AA 02 00 78 56 34 12 EF BE AD DE 55 -> two writes, with cpu_rst high from after AA until done:
- addr 0 = 12345678;
- addr 1 = DEADBEEF;
- done pulse after the 55.
REQ-037 Stream AA 00 00 55 -> no write, done pulse, err=0.
REQ-038 Stream AA 01 00 11 22 33 44 66 -> one write of 44332211, then err=1, done=0, IDLE, cpu_rst=0.
REQ-039 Stream AA 01 00 11 22, then silence for TIMEOUT_CYC cycles -> err=1, no write, busy=0.
REQ-040 rst pulsed after AA 02 00 11 -> no writes, all outputs at reset values; a following complete stream loads correctly.
REQ-041 Stray bytes 00 55 FF in IDLE -> no state change, err unchanged.
